ts_channel_scheduler: RTL and testbench

Packet-granular round-robin scheduler for the 4-channel MPEG-2 TS output multiplexer. It grants one channel at a time for exactly one full TS packet, and drives the multiplexer's channel select (mux_ctrl) and enable (en_mux). It counts valid bytes of the granted channel, acknowledges each completed packet, and aborts a grant if the granted source stalls.

---
 rtl/ts_channel_scheduler.sv | 128 ++++++++++++
 tb/tb_ts_channel_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ts_channel_scheduler.sv
// Packet-granular round-robin scheduler for a 4-channel TS output multiplexer.
// Grants one channel for exactly one packet and aborts the grant if the source stalls.
module ts_channel_scheduler #(
    parameter int PKT_LEN = 188,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] pkt_avail,
    input  logic [3:0] valid,
    output logic [1:0] mux_ctrl,
    output logic       en_mux,
    output logic [3:0] pkt_ack,
    output logic       timeout_err,
    output logic       busy,
    output logic [7:0] byte_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_XFER  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_ABORT = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  mux_ctrl_q, mux_ctrl_d;
    logic        en_mux_q, en_mux_d;
    logic [3:0]  pkt_ack_q, pkt_ack_d;
    logic        timeout_err_q, timeout_err_d;
    logic        busy_q, busy_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic [1:0]  pick, idx;
    logic        found;

    // Search starts just after the last served channel; the last one is tried last.
    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!found && pkt_avail[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        mux_ctrl_d    = mux_ctrl_q;
        en_mux_d      = 1'b0;
        pkt_ack_d     = 4'b0000;
        timeout_err_d = 1'b0;
        byte_cnt_d    = byte_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    mux_ctrl_d  = pick;
                    byte_cnt_d  = 8'd0;
                    stall_cnt_d = 16'd0;
                    en_mux_d    = 1'b1;
                    state_d     = S_XFER;
                end
            end
            S_XFER: begin
                en_mux_d = 1'b1;
                if (valid[mux_ctrl_q]) begin
                    byte_cnt_d  = byte_cnt_q + 8'd1;
                    stall_cnt_d = 16'd0;
                    if (byte_cnt_q == 8'(PKT_LEN - 1)) begin
                        en_mux_d  = 1'b0;
                        pkt_ack_d = 4'b0001 << mux_ctrl_q;
                        last_d    = mux_ctrl_q;
                        state_d   = S_DONE;
                    end
                end else begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                    // A stalled channel is charged its turn, same as a completed one.
                    if (stall_cnt_q == 16'(TIMEOUT - 1)) begin
                        en_mux_d      = 1'b0;
                        timeout_err_d = 1'b1;
                        last_d        = mux_ctrl_q;
                        state_d       = S_ABORT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            last_q        <= 2'd3;
            mux_ctrl_q    <= 2'd0;
            en_mux_q      <= 1'b0;
            pkt_ack_q     <= 4'b0000;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            byte_cnt_q    <= 8'd0;
            stall_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            mux_ctrl_q    <= mux_ctrl_d;
            en_mux_q      <= en_mux_d;
            pkt_ack_q     <= pkt_ack_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            byte_cnt_q    <= byte_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign mux_ctrl    = mux_ctrl_q;
    assign en_mux      = en_mux_q;
    assign pkt_ack     = pkt_ack_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;
    assign byte_cnt    = byte_cnt_q;

endmodule

// File: tb/tb_ts_channel_scheduler.sv
// Directed bench for ts_channel_scheduler: reset, single packet, fairness,
// gapped source, stall timeout and reset mid-packet.
module tb_ts_channel_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pkt_avail;
    logic [3:0] valid;
    logic [1:0] mux_ctrl;
    logic       en_mux;
    logic [3:0] pkt_ack;
    logic       timeout_err;
    logic       busy;
    logic [7:0] byte_cnt;

    int checks = 0;
    int errors = 0;
    int cnt;
    logic tout_seen;

    ts_channel_scheduler #(.PKT_LEN(188), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .pkt_avail(pkt_avail), .valid(valid),
        .mux_ctrl(mux_ctrl), .en_mux(en_mux), .pkt_ack(pkt_ack),
        .timeout_err(timeout_err), .busy(busy), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps through XFER while en_mux is high, counting its cycles.
    // mode 1: valid[1] alternates 1,0,...; mode 2: valid[3] high for first 100 cycles.
    task automatic run_xfer(input int mode, output int n, output logic tout);
        n = 0;
        tout = 1'b0;
        while (en_mux && n < 1000) begin
            if (mode == 1) valid[1] = (n % 2 == 0);
            if (mode == 2) valid[3] = (n < 100);
            tout = tout | timeout_err;
            n++;
            step();
        end
    endtask

    initial begin
        // 1. reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pkt_avail = 4'($urandom);
            valid     = 4'($urandom);
            step();
        end
        chk("rst_mux_ctrl", 32'(mux_ctrl), 32'd0);
        chk("rst_en_mux", 32'(en_mux), 32'd0);
        chk("rst_pkt_ack", 32'(pkt_ack), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        rst = 1'b0;
        pkt_avail = 4'b1111;
        valid = 4'b1111;
        step();
        chk("first_grant_mux", 32'(mux_ctrl), 32'd0);
        chk("first_grant_en", 32'(en_mux), 32'd1);
        chk("first_grant_busy", 32'(busy), 32'd1);
        pkt_avail = 4'b0000;
        run_xfer(0, cnt, tout_seen);
        chk("first_pkt_len", 32'(cnt), 32'd188);
        chk("first_pkt_ack", 32'(pkt_ack), 32'b0001);
        step();
        chk("first_idle_busy", 32'(busy), 32'd0);

        // 2. single packet on ch2
        pkt_avail = 4'b0100;
        valid = 4'b0100;
        step();
        chk("single_en", 32'(en_mux), 32'd1);
        chk("single_mux", 32'(mux_ctrl), 32'd2);
        chk("single_cnt0", 32'(byte_cnt), 32'd0);
        pkt_avail = 4'b0000;
        run_xfer(0, cnt, tout_seen);
        chk("single_len", 32'(cnt), 32'd188);
        chk("single_ack", 32'(pkt_ack), 32'b0100);
        chk("single_byte_cnt", 32'(byte_cnt), 32'd188);
        chk("single_done_busy", 32'(busy), 32'd1);
        step();
        chk("single_ack_clear", 32'(pkt_ack), 32'd0);
        chk("single_hold_cnt", 32'(byte_cnt), 32'd188);

        // 3. fairness from reset: 0,1,2,3,0
        rst = 1'b1;
        step();
        rst = 1'b0;
        pkt_avail = 4'b1111;
        valid = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            chk("fair_mux", 32'(mux_ctrl), 32'(g % 4));
            chk("fair_en", 32'(en_mux), 32'd1);
            if (g == 4) pkt_avail = 4'b0000;
            run_xfer(0, cnt, tout_seen);
            chk("fair_len", 32'(cnt), 32'd188);
            chk("fair_ack", 32'(pkt_ack), 32'(4'b0001 << (g % 4)));
            step();
            chk("fair_gap_en", 32'(en_mux), 32'd0);
            chk("fair_gap_ack", 32'(pkt_ack), 32'd0);
            if (g < 4) step();
        end
        chk("fair_end_busy", 32'(busy), 32'd0);

        // 4. gapped source on ch1 (last=0, so ch1 next)
        pkt_avail = 4'b0010;
        valid = 4'b1101;
        step();
        chk("gap_mux", 32'(mux_ctrl), 32'd1);
        pkt_avail = 4'b0000;
        run_xfer(1, cnt, tout_seen);
        chk("gap_len", 32'(cnt), 32'd375);
        chk("gap_ack", 32'(pkt_ack), 32'b0010);
        chk("gap_no_tout", 32'(tout_seen | timeout_err), 32'd0);
        step();

        // 5. timeout on ch3 (last=1, order 2,3,0,1)
        pkt_avail = 4'b1001;
        valid = 4'b1000;
        step();
        chk("tout_mux", 32'(mux_ctrl), 32'd3);
        run_xfer(2, cnt, tout_seen);
        chk("tout_len", 32'(cnt), 32'd116);
        chk("tout_early", 32'(tout_seen), 32'd0);
        chk("tout_err", 32'(timeout_err), 32'd1);
        chk("tout_no_ack", 32'(pkt_ack), 32'd0);
        chk("tout_byte_cnt", 32'(byte_cnt), 32'd100);
        step();
        chk("tout_pulse_once", 32'(timeout_err), 32'd0);
        chk("tout_idle_cnt", 32'(byte_cnt), 32'd100);
        step();
        chk("tout_next_mux", 32'(mux_ctrl), 32'd0);
        chk("tout_next_en", 32'(en_mux), 32'd1);

        // 6. reset at byte 90 of a ch2 grant
        rst = 1'b1;
        step();
        rst = 1'b0;
        pkt_avail = 4'b0100;
        valid = 4'b0100;
        step();
        chk("midrst_mux", 32'(mux_ctrl), 32'd2);
        for (int i = 0; i < 90; i++) step();
        chk("midrst_cnt90", 32'(byte_cnt), 32'd90);
        rst = 1'b1;
        step();
        rst = 1'b0;
        pkt_avail = 4'b0101;
        chk("midrst_en", 32'(en_mux), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_byte_cnt", 32'(byte_cnt), 32'd0);
        chk("midrst_ack", 32'(pkt_ack), 32'd0);
        chk("midrst_tout", 32'(timeout_err), 32'd0);
        step();
        chk("midrst_next_mux", 32'(mux_ctrl), 32'd0);
        chk("midrst_next_en", 32'(en_mux), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
